hbridge_driver: RTL and testbench
=================================

# hbridge_driver

Drives the two H-bridge channels (left and right drive motors) from the rover's direction/enable command bus. It consumes the 4-bit direction code and 2-bit enable produced by the line-following motor controller. It produces bridge input pins and per-channel PWM enables, with three protections: soft-start ramping, an enforced dead time on every direction reversal, and immediate shutdown when enable drops.

## Interface
- `DUTY_MAX`, 8'd200: saturating run duty (out of 256).
- `RAMP_STEP`, 8'd8: duty increment per ramp tick.
- `RAMP_DIV`, 16'd1000: clock cycles per ramp tick.
- `DEAD_CYCLES`, 16'd500: cycles both bridge pins are held low on reversal.
- `PWM_DIV`, 8'd4: clock cycles per PWM counter increment.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `motor_in` in 4: command; [3:2] left, [1:0] right; per channel 2'b10 or 2'b01 = direction, 2'b00/2'b11 = stop. Asynchronous to `clk`.
- `motor_en` in 2: [1] left, [0] right channel enable. Asynchronous to `clk`.
- `bridge_dir` out 4: bridge input pins, same bit mapping as `motor_in`.
- `bridge_pwm` out 2: PWM enable pins, [1] left, [0] right.
- `state_l`, `state_r` out 2 each: channel FSM state (debug).

## Operation
- `motor_in` and `motor_en` pass through a 2-flop synchronizer. All decisions use the synchronized values.
- There is one shared free-running 8-bit `pwm_cnt`. It increments once every `PWM_DIV` clocks and wraps 255→0.
- Each channel has an independent FSM with states STOP=0, RAMP=1, RUN=2, DEAD=3.
- A channel's command is *valid* when its enable is 1 and its code is 10 or 01.
- STOP:
  - `bridge_dir` pair = 00, duty = 0.
  - On a valid command: latch the direction and go to RAMP.
- RAMP:
  - Every `RAMP_DIV` cycles, duty ← min(duty + `RAMP_STEP`, `DUTY_MAX`). The sum is computed 9 bits wide.
  - When duty reaches `DUTY_MAX`, go to RUN.
- RUN: hold duty at `DUTY_MAX`.
- DEAD:
  - Pair = 00 and duty = 0 for `DEAD_CYCLES` cycles, then go to RAMP with the latched new direction.
  - A further direction change during DEAD latches the newest direction and restarts the dead counter.
- Transitions valid in any state:
  - Enable = 0, or stop code (00/11) → STOP next cycle.
  - In RAMP or RUN, a valid opposite direction → DEAD, with the new direction latched.
  - Same direction re-asserted → no effect.
- Simultaneous events:
  - Enable drop together with a direction change → STOP wins.
  - Reset has priority over everything.
- Outputs:
  - `bridge_dir` pair = latched direction in RAMP/RUN, else 00.
  - `bridge_pwm[m]` = (RAMP or RUN) && (`pwm_cnt` < duty).
  - Duty 0 gives a constant low. `DUTY_MAX` = 255 gives 255/256 high.
- Reset mid-operation: every channel returns to STOP and all counters clear. There is no dead time on reset exit because pins are already low.

## Timing
- Reset values:
  - `bridge_dir` = 4'b0000.
  - `bridge_pwm` = 2'b00.
  - `state_l` = `state_r` = 0.
  - Duty, `pwm_cnt`, ramp timer and dead timer all = 0.
- All outputs are registered.
- Latency from an input edge to the FSM state change is 3 clocks (2 synchronizer + 1 FSM). The output follows in the same cycle as the state change.
- `bridge_pwm` drops 3 clocks after `motor_en` falls, regardless of state.
- The ramp timer restarts at RAMP entry. The first increment occurs `RAMP_DIV` cycles after entry.
- Time from STOP to RUN = ceil(`DUTY_MAX`/`RAMP_STEP`) × `RAMP_DIV` cycles.
- The dead counter starts at DEAD entry. RAMP entry occurs exactly `DEAD_CYCLES` cycles later.

## Configuration
- `HBRIDGE_SOFTSTART_EN`:
  - Defined: ramping behaves as described above.
  - Undefined: RAMP is never entered. STOP and DEAD-expiry go straight to RUN with duty = `DUTY_MAX`, and the ramp timer is not built.
- Dead time and the synchronizer are present in both builds.

## Test plan
Bench parameters: `DUTY_MAX`=16, `RAMP_STEP`=4, `RAMP_DIV`=2, `DEAD_CYCLES`=3, `PWM_DIV`=1, softstart enabled.
- Reset → all outputs 0. Release, `motor_en`=11, `motor_in`=1010 → after 3 clocks `bridge_dir`=1010 and both states RAMP. Duty steps 4, 8, 12, 16 every 2 clocks, then RUN.
- In RUN, left code changes 10→01 → left state=DEAD, left pair=00, `bridge_pwm[1]`=0 for 3 clocks. Then RAMP with pair 01, duty restarts from 0. Right channel is undisturbed.
- Drop `motor_en[0]` while the right channel is in RAMP, and change its direction in the same cycle → right state=STOP (not DEAD), pair=00 within 3 clocks.
- In RUN with duty 16, count `bridge_pwm` high cycles over one 256-cycle PWM period → exactly 16. With code 11 → 0.
- Assert `rst_n`=0 mid-DEAD → all outputs 0 asynchronously. After release with the command held → RAMP without a dead interval.
- Softstart macro undefined: enable from STOP → RUN and duty 16 within 3 clocks.

Source files
------------

// File: rtl/hbridge_driver.sv
// hbridge_driver
//   Drives the left and right H-bridge channels from the direction/enable
//   command bus. Each channel soft-starts, enforces a dead time on every
//   direction reversal, and shuts down as soon as its enable drops.
//
// Build option:
//   HBRIDGE_SOFTSTART_EN  defined   -> duty ramps from 0 up to DUTY_MAX
//                         undefined -> channels jump straight to RUN at DUTY_MAX,
//                                      and no ramp timer is built
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   motor_in    [3:2] left / [1:0] right code (10/01 = direction, 00/11 = stop), async
//   motor_en    [1] left / [0] right enable, async
//   bridge_dir  bridge input pins, same mapping as motor_in (registered)
//   bridge_pwm  PWM enables, [1] left / [0] right (registered)
//   state_l     left channel FSM state  (0 STOP, 1 RAMP, 2 RUN, 3 DEAD)
//   state_r     right channel FSM state (same encoding)
module hbridge_driver #(
    parameter logic [7:0]  DUTY_MAX    = 8'd200,
    parameter logic [7:0]  RAMP_STEP   = 8'd8,
    parameter logic [15:0] RAMP_DIV    = 16'd1000,
    parameter logic [15:0] DEAD_CYCLES = 16'd500,
    parameter logic [7:0]  PWM_DIV     = 8'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] motor_in,
    input  logic [1:0] motor_en,
    output logic [3:0] bridge_dir,
    output logic [1:0] bridge_pwm,
    output logic [1:0] state_l,
    output logic [1:0] state_r
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_t;

    // {motor_en, motor_in} after each synchronizer stage
    logic [5:0] sync1_r;
    logic [5:0] sync2_r;

    logic [7:0] pwm_div_r;
    logic [7:0] pwm_div_nxt_s;
    logic [7:0] pwm_cnt_r;
    logic [7:0] pwm_cnt_nxt_s;

`ifndef HBRIDGE_SOFTSTART_EN
    // The ramp parameters have no function without soft-start; sink them so
    // the parameter list stays identical between builds.
    logic unused_ramp_s;
    assign unused_ramp_s = ^{RAMP_STEP, RAMP_DIV};
`endif

    // Two-flop synchronizer for the asynchronous command bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 6'd0;
            sync2_r <= 6'd0;
        end else begin
            sync1_r <= {motor_en, motor_in};
            sync2_r <= sync1_r;
        end
    end

    // Next value of the prescaler and the shared free-running PWM counter
    always_comb begin
        pwm_div_nxt_s = pwm_div_r + 8'd1;
        pwm_cnt_nxt_s = pwm_cnt_r;
        if (pwm_div_r >= PWM_DIV - 8'd1) begin
            pwm_div_nxt_s = 8'd0;
            pwm_cnt_nxt_s = pwm_cnt_r + 8'd1;
        end else begin
            pwm_cnt_nxt_s = pwm_cnt_r;
        end
    end

    // PWM prescaler and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_div_r <= 8'd0;
            pwm_cnt_r <= 8'd0;
        end else begin
            pwm_div_r <= pwm_div_nxt_s;
            pwm_cnt_r <= pwm_cnt_nxt_s;
        end
    end

    // ch 0 = right, ch 1 = left
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        ch_state_t   ch_state_r;
        ch_state_t   ch_state_nxt_s;
        logic [1:0]  code_s;
        logic        en_s;
        logic        valid_s;
        logic        drive_nxt_s;
        logic [1:0]  dir_r;
        logic [1:0]  dir_nxt_s;
        logic [7:0]  duty_r;
        logic [7:0]  duty_nxt_s;
        logic [15:0] dead_tmr_r;
        logic [15:0] dead_tmr_nxt_s;
        logic [1:0]  pair_r;
        logic        pwm_r;
`ifdef HBRIDGE_SOFTSTART_EN
        logic [15:0] ramp_tmr_r;
        logic [15:0] ramp_tmr_nxt_s;
        logic [8:0]  ramp_sum_s;
`endif

        assign code_s  = sync2_r[2*ch+1 -: 2];
        assign en_s    = sync2_r[4+ch];
        assign valid_s = en_s & ((code_s == 2'b10) | (code_s == 2'b01));

        // Channel next-state logic; an invalid command (stop code or enable
        // low) overrides everything, so a simultaneous reversal lands in STOP
        always_comb begin
            ch_state_nxt_s = ch_state_r;
            dir_nxt_s      = dir_r;
            duty_nxt_s     = duty_r;
            dead_tmr_nxt_s = 16'd0;
`ifdef HBRIDGE_SOFTSTART_EN
            ramp_tmr_nxt_s = 16'd0;
            ramp_sum_s     = {1'b0, duty_r} + {1'b0, RAMP_STEP};
`endif
            if (!valid_s) begin
                ch_state_nxt_s = ST_STOP;
                duty_nxt_s     = 8'd0;
            end else begin
                case (ch_state_r)
                    ST_STOP: begin
                        dir_nxt_s = code_s;
`ifdef HBRIDGE_SOFTSTART_EN
                        ch_state_nxt_s = ST_RAMP;
                        duty_nxt_s     = 8'd0;
`else
                        ch_state_nxt_s = ST_RUN;
                        duty_nxt_s     = DUTY_MAX;
`endif
                    end
                    ST_RAMP: begin
                        if (code_s != dir_r) begin
                            ch_state_nxt_s = ST_DEAD;
                            dir_nxt_s      = code_s;
                            duty_nxt_s     = 8'd0;
                        end else begin
`ifdef HBRIDGE_SOFTSTART_EN
                            if (ramp_tmr_r >= RAMP_DIV - 16'd1) begin
                                // 9-bit sum so a step past 255 still saturates
                                if (ramp_sum_s >= {1'b0, DUTY_MAX}) begin
                                    duty_nxt_s     = DUTY_MAX;
                                    ch_state_nxt_s = ST_RUN;
                                end else begin
                                    duty_nxt_s = ramp_sum_s[7:0];
                                end
                            end else begin
                                ramp_tmr_nxt_s = ramp_tmr_r + 16'd1;
                            end
`else
                            ch_state_nxt_s = ST_RUN;
                            duty_nxt_s     = DUTY_MAX;
`endif
                        end
                    end
                    ST_RUN: begin
                        if (code_s != dir_r) begin
                            ch_state_nxt_s = ST_DEAD;
                            dir_nxt_s      = code_s;
                            duty_nxt_s     = 8'd0;
                        end else begin
                            duty_nxt_s = DUTY_MAX;
                        end
                    end
                    ST_DEAD: begin
                        duty_nxt_s = 8'd0;
                        if (code_s != dir_r) begin
                            // newest reversal wins and the dead time restarts
                            dir_nxt_s = code_s;
                        end else if (dead_tmr_r >= DEAD_CYCLES - 16'd1) begin
`ifdef HBRIDGE_SOFTSTART_EN
                            ch_state_nxt_s = ST_RAMP;
`else
                            ch_state_nxt_s = ST_RUN;
                            duty_nxt_s     = DUTY_MAX;
`endif
                        end else begin
                            dead_tmr_nxt_s = dead_tmr_r + 16'd1;
                        end
                    end
                    default: begin
                        ch_state_nxt_s = ST_STOP;
                        duty_nxt_s     = 8'd0;
                    end
                endcase
            end
        end

        assign drive_nxt_s = (ch_state_nxt_s == ST_RAMP) | (ch_state_nxt_s == ST_RUN);

        // Channel state and outputs; outputs are built from next-state values
        // so the pins change on the same edge as the FSM
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ch_state_r <= ST_STOP;
                dir_r      <= 2'b00;
                duty_r     <= 8'd0;
                dead_tmr_r <= 16'd0;
                pair_r     <= 2'b00;
                pwm_r      <= 1'b0;
`ifdef HBRIDGE_SOFTSTART_EN
                ramp_tmr_r <= 16'd0;
`endif
            end else begin
                ch_state_r <= ch_state_nxt_s;
                dir_r      <= dir_nxt_s;
                duty_r     <= duty_nxt_s;
                dead_tmr_r <= dead_tmr_nxt_s;
                pair_r     <= drive_nxt_s ? dir_nxt_s : 2'b00;
                pwm_r      <= drive_nxt_s & (pwm_cnt_nxt_s < duty_nxt_s);
`ifdef HBRIDGE_SOFTSTART_EN
                ramp_tmr_r <= ramp_tmr_nxt_s;
`endif
            end
        end
    end

    assign bridge_dir = {g_ch[1].pair_r, g_ch[0].pair_r};
    assign bridge_pwm = {g_ch[1].pwm_r, g_ch[0].pwm_r};
    assign state_l    = g_ch[1].ch_state_r;
    assign state_r    = g_ch[0].ch_state_r;

endmodule

// File: tb/tb_hbridge_driver.sv
// tb_hbridge_driver
//   Self-checking bench for hbridge_driver with small timing parameters.
//   A behavioural model (duty as a closed-form function of time spent in
//   RAMP, counters as elapsed-cycle ages) predicts every output each cycle.
module tb_hbridge_driver;

    localparam int T_DUTY_MAX = 16;
    localparam int T_STEP     = 4;
    localparam int T_RDIV     = 2;
    localparam int T_DEAD     = 3;
    localparam int T_PDIV     = 1;
`ifdef HBRIDGE_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int M_STOP = 0;
    localparam int M_RAMP = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEAD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] motor_in;
    logic [1:0] motor_en;
    logic [3:0] bridge_dir;
    logic [1:0] bridge_pwm;
    logic [1:0] state_l;
    logic [1:0] state_r;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // reference model state, index 0 = right, 1 = left
    int         m_st[2];
    int         m_dir[2];
    int         m_duty[2];
    int         m_age[2];
    logic [3:0] q_in[2];
    logic [1:0] q_en[2];
    int         pwm_edges;

    hbridge_driver #(
        .DUTY_MAX   (8'd16),
        .RAMP_STEP  (8'd4),
        .RAMP_DIV   (16'd2),
        .DEAD_CYCLES(16'd3),
        .PWM_DIV    (8'd1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .motor_in  (motor_in),
        .motor_en  (motor_en),
        .bridge_dir(bridge_dir),
        .bridge_pwm(bridge_pwm),
        .state_l   (state_l),
        .state_r   (state_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_st[c]   = M_STOP;
            m_dir[c]  = 0;
            m_duty[c] = 0;
            m_age[c]  = 0;
            q_in[c]   = 4'd0;
            q_en[c]   = 2'd0;
        end
        pwm_edges = 0;
    endfunction

    function automatic void start_drive(input int c);
        m_age[c] = 0;
        if (SOFT) begin
            m_st[c]   = M_RAMP;
            m_duty[c] = 0;
        end else begin
            m_st[c]   = M_RUN;
            m_duty[c] = T_DUTY_MAX;
        end
    endfunction

    // one rising edge: the channels act on what was applied two edges earlier
    function automatic void model_edge();
        logic [3:0] use_in;
        logic [1:0] use_en;
        int code;
        bit valid;
        use_in = q_in[1];
        use_en = q_en[1];
        for (int c = 0; c < 2; c++) begin
            code  = (int'(use_in) >> (2 * c)) & 3;
            valid = use_en[c] && (code == 1 || code == 2);
            if (!valid) begin
                m_st[c]   = M_STOP;
                m_duty[c] = 0;
                m_age[c]  = 0;
            end else if (m_st[c] == M_STOP) begin
                m_dir[c] = code;
                start_drive(c);
            end else if (code != m_dir[c]) begin
                // reversal from RAMP/RUN enters DEAD; inside DEAD it restarts it
                m_dir[c]  = code;
                m_st[c]   = M_DEAD;
                m_duty[c] = 0;
                m_age[c]  = 0;
            end else if (m_st[c] == M_RAMP) begin
                m_age[c]++;
                m_duty[c] = (m_age[c] / T_RDIV) * T_STEP;
                if (m_duty[c] >= T_DUTY_MAX) begin
                    m_duty[c] = T_DUTY_MAX;
                    m_st[c]   = M_RUN;
                end
            end else if (m_st[c] == M_DEAD) begin
                m_age[c]++;
                if (m_age[c] == T_DEAD) start_drive(c);
            end
        end
        q_in[1] = q_in[0];
        q_en[1] = q_en[0];
        q_in[0] = motor_in;
        q_en[0] = motor_en;
        pwm_edges++;
    endfunction

    task automatic compare_all();
        logic [3:0] e_dir;
        logic [1:0] e_pwm;
        int cnt;
        e_dir = 4'd0;
        e_pwm = 2'd0;
        cnt   = (pwm_edges / T_PDIV) % 256;
        for (int c = 0; c < 2; c++) begin
            if (m_st[c] == M_RAMP || m_st[c] == M_RUN) begin
                e_dir = e_dir | 4'(m_dir[c] << (2 * c));
                if (cnt < m_duty[c]) e_pwm[c] = 1'b1;
            end
        end
        chk("dir", 32'(bridge_dir), 32'(e_dir));
        chk("pwm", 32'(bridge_pwm), 32'(e_pwm));
        chk("st_l", 32'(state_l), 32'(m_st[1]));
        chk("st_r", 32'(state_r), 32'(m_st[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({bridge_dir, bridge_pwm, state_l, state_r}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int hold;
        rst_n    = 1'b0;
        motor_in = 4'b0000;
        motor_en = 2'b00;
        model_reset();
        #12;
        chk_all_zero("reset_outputs");
        #10;
        rst_n    = 1'b1;
        motor_en = 2'b11;
        motor_in = 4'b1010;
        repeat (3) tick();
        chk("start_dir", 32'(bridge_dir), 32'(4'b1010));
        chk("start_state", 32'(state_l), SOFT ? 32'd1 : 32'd2);
        repeat (10) tick();

        // left reversal while both run
        motor_in = 4'b0110;
        repeat (3) tick();
        chk("rev_dead", 32'(state_l), 32'd3);
        repeat (9) tick();

        // right stopped, restarted, then enable drop with reversal in RAMP
        motor_in = 4'b0100;
        repeat (5) tick();
        motor_in = 4'b0101;
        repeat (4) tick();
        chk("right_ramp", 32'(state_r), SOFT ? 32'd1 : 32'd2);
        motor_en = 2'b10;
        motor_in = 4'b0110;
        repeat (3) tick();
        chk("drop_stop", 32'(state_r), 32'd0);
        chk("drop_pair", 32'(bridge_dir[1:0]), 32'd0);

        // duty cycle over one full PWM period
        motor_en = 2'b11;
        motor_in = 4'b1010;
        repeat (30) tick();
        hi = 0;
        repeat (256) begin
            tick();
            hi += int'(bridge_pwm[1]);
        end
        chk("pwm_hi_full", 32'(hi), 32'(T_DUTY_MAX));
        motor_in = 4'b1110;
        repeat (4) tick();
        hi = 0;
        repeat (256) begin
            tick();
            hi += int'(bridge_pwm[1]);
        end
        chk("pwm_hi_stop", 32'(hi), 32'd0);

        // reset in the middle of a dead interval
        motor_in = 4'b1010;
        repeat (15) tick();
        motor_in = 4'b0110;
        repeat (4) tick();
        chk("pre_rst_dead", 32'(state_l), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        #3;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_exit_state", 32'(state_l), SOFT ? 32'd1 : 32'd2);
        chk("rst_exit_dir", 32'(bridge_dir), 32'(4'b0110));

        // randomized commands held for random spans
        hold = 0;
        repeat (2000) begin
            if (hold == 0) begin
                motor_en = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
                motor_in = 4'($urandom_range(0, 15));
                hold     = $urandom_range(1, 15);
            end
            hold--;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
